// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes and scheduler state encoding
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } sched_state_t;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// rtl/axi4_lite_addr_decode.sv - address to {hit, index, one-hot select}
module axi4_lite_addr_decode #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_PERIPH    = 4,
  parameter int REGION_LSB    = 12
) (
  input  logic [ADDRESS_WIDTH-1:REGION_LSB]  addr,
  output logic                               hit,
  output logic [$clog2(NUM_PERIPH)-1:0]      idx,
  output logic [NUM_PERIPH-1:0]              sel
);

  localparam int IDX_W = $clog2(NUM_PERIPH);
  localparam int TOP   = REGION_LSB + IDX_W;

  assign idx = addr[REGION_LSB +: IDX_W];

  // Any address bit above the index field means no peripheral lives there.
  generate
    if (TOP < ADDRESS_WIDTH) begin : g_upper
      assign hit = ~|addr[ADDRESS_WIDTH-1:TOP];
    end else begin : g_full
      assign hit = 1'b1;
    end
  endgenerate

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
  end

endmodule

// File: rtl/axi4_lite_periph_sched.sv
// rtl/axi4_lite_periph_sched.sv - serialises write/read requests onto one peripheral bus
module axi4_lite_periph_sched
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int NUM_PERIPH     = 4,
  parameter int REGION_LSB     = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic                             req_write,
  input  logic [ADDRESS_WIDTH-1:0]         req_waddr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_wstrb,
  input  logic                             req_read,
  input  logic [ADDRESS_WIDTH-1:0]         req_raddr,
  output logic                             write_done,
  output logic [1:0]                       bresp,
  output logic                             read_done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic [NUM_PERIPH-1:0]            per_sel,
  output logic                             per_valid,
  output logic                             per_we,
  output logic [ADDRESS_WIDTH-1:0]         per_addr,
  output logic [DATA_WIDTH-1:0]            per_wdata,
  output logic [DATA_WIDTH/8-1:0]          per_wstrb,
  input  logic [NUM_PERIPH-1:0]            per_ready,
  input  logic [NUM_PERIPH-1:0]            per_err,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] per_rdata
);

  localparam int IDX_W  = $clog2(NUM_PERIPH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t state, state_nxt;

  logic                     wr_pend, rd_pend;
  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [STRB_W-1:0]        wr_strb;
  logic                     cur_we;
  logic                     write_prio;
  logic [CNT_W-1:0]         cnt;
  resp_t                    resp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic                     grant_we, acc_we;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic                     dec_hit;
  logic [IDX_W-1:0]         dec_idx;
  logic [NUM_PERIPH-1:0]    dec_sel;
  logic                     sel_ready, sel_err, timed_out;
  logic                     clear_wr, clear_rd;

  // Pend registers stay stable while granted, so the access reads them directly.
  always_comb begin
    grant_we  = wr_pend & (~rd_pend | write_prio);
    acc_we    = (state == IDLE) ? grant_we : cur_we;
    acc_addr  = acc_we ? wr_addr : rd_addr;
    sel_ready = per_ready[dec_idx];
    sel_err   = per_err[dec_idx];
    timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    clear_wr  = (state == RESP) & cur_we;
    clear_rd  = (state == RESP) & ~cur_we;
  end

  axi4_lite_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_PERIPH    (NUM_PERIPH),
    .REGION_LSB    (REGION_LSB)
  ) u_decode (
    .addr (acc_addr[ADDRESS_WIDTH-1:REGION_LSB]),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .sel  (dec_sel)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_pend | rd_pend) state_nxt = dec_hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready | timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_pend    <= 1'b0;
      rd_pend    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
      cur_we     <= 1'b0;
      write_prio <= 1'b1;
      cnt        <= '0;
      resp_q     <= OKAY;
      rdata_q    <= '0;
    end else begin
      // Clearing a finished pend and capturing a new pulse can share an edge.
      if (req_write && (!wr_pend || clear_wr)) begin
        wr_pend <= 1'b1;
        wr_addr <= req_waddr;
        wr_data <= req_wdata;
        wr_strb <= req_wstrb;
      end else if (clear_wr) begin
        wr_pend <= 1'b0;
      end
      if (req_read && (!rd_pend || clear_rd)) begin
        rd_pend <= 1'b1;
        rd_addr <= req_raddr;
      end else if (clear_rd) begin
        rd_pend <= 1'b0;
      end

      case (state)
        IDLE: if (wr_pend | rd_pend) begin
          cur_we <= grant_we;
          // Priority only flips when both types actually contended.
          if (wr_pend && rd_pend) write_prio <= ~grant_we;
          if (!dec_hit) begin
            resp_q  <= DECERR;
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (sel_ready) begin
            resp_q  <= sel_err ? SLVERR : OKAY;
            rdata_q <= (cur_we || sel_err) ? '0
                       : per_rdata[dec_idx*DATA_WIDTH +: DATA_WIDTH];
          end else if (timed_out) begin
            resp_q  <= SLVERR;
            rdata_q <= '0;
          end
        end
        RESP:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    per_valid  = (state == ACCESS);
    per_sel    = per_valid ? dec_sel : '0;
    per_we     = per_valid & cur_we;
    per_addr   = per_valid ? acc_addr : '0;
    per_wdata  = per_we ? wr_data : '0;
    per_wstrb  = per_we ? wr_strb : '0;
    write_done = (state == RESP) & cur_we;
    read_done  = (state == RESP) & ~cur_we;
    bresp      = write_done ? resp_q : OKAY;
    rresp      = read_done ? resp_q : OKAY;
    rdata      = read_done ? rdata_q : '0;
  end

endmodule

// File: tb/tb_axi4_lite_periph_sched.sv
// tb/tb_axi4_lite_periph_sched.sv - vector table plus scoreboard bench for the scheduler
module tb_axi4_lite_periph_sched;

  logic         aclk = 1'b0;
  logic         arst_n = 1'b0;
  logic         req_write = 1'b0, req_read = 1'b0;
  logic [31:0]  req_waddr = '0, req_wdata = '0, req_raddr = '0;
  logic [3:0]   req_wstrb = '0;
  logic         write_done, read_done, per_valid, per_we;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, per_addr, per_wdata;
  logic [3:0]   per_sel, per_wstrb;
  logic [3:0]   per_ready = '0, per_err = '0;
  logic [127:0] per_rdata;

  always #5 aclk = ~aclk;

  assign per_rdata = {32'h3333_4444, 32'h1234_5678, 32'h1111_2222, 32'hCAFE_0000};

  axi4_lite_periph_sched #(.TIMEOUT_CYCLES(8)) dut (
    .ACLK(aclk), .ARESETn(arst_n),
    .req_write(req_write), .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_read(req_read), .req_raddr(req_raddr),
    .write_done(write_done), .bresp(bresp), .read_done(read_done), .rdata(rdata), .rresp(rresp),
    .per_sel(per_sel), .per_valid(per_valid), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_wstrb(per_wstrb),
    .per_ready(per_ready), .per_err(per_err), .per_rdata(per_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge aclk) begin
    if (arst_n) begin
      if (write_done && read_done) chk("done_exclusive", 1, 0);
      if (write_done || read_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {write_done, read_done}, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_type", write_done, e.we);
          chk("done_resp", write_done ? bresp : rresp, e.resp);
          if (read_done) chk("done_rdata", rdata, e.rdata);
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          delay;   // -1: never ready
    logic        err;
    logic [3:0]  sel;     // 0: decode error
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int id);
    logic [3:0] other;
    int vcnt;
    other = {v.sel[2:0], v.sel[3]};
    @(negedge aclk);
    if (v.we) begin
      req_write = 1'b1; req_waddr = v.addr; req_wdata = v.wdata; req_wstrb = v.strb;
    end else begin
      req_read = 1'b1; req_raddr = v.addr;
    end
    sb_q.push_back('{v.we, v.resp, v.rdata});
    @(negedge aclk);
    req_write = 1'b0; req_read = 1'b0;
    chk($sformatf("v%0d_c1_valid", id), per_valid, 0);
    @(negedge aclk);
    if (v.sel == 4'b0000) begin
      chk($sformatf("v%0d_decerr_done_c2", id), write_done | read_done, 1);
      chk($sformatf("v%0d_decerr_valid", id), per_valid, 0);
    end else begin
      chk($sformatf("v%0d_c2_valid", id), per_valid, 1);
      chk($sformatf("v%0d_sel", id), per_sel, v.sel);
      chk($sformatf("v%0d_we", id), per_we, v.we);
      chk($sformatf("v%0d_addr", id), per_addr, v.addr);
      if (v.we) begin
        chk($sformatf("v%0d_wdata", id), per_wdata, v.wdata);
        chk($sformatf("v%0d_wstrb", id), per_wstrb, v.strb);
      end
      per_ready = other; per_err = other;
      if (v.delay >= 0) begin
        repeat (v.delay) @(negedge aclk);
        per_ready = v.sel | other;
        per_err   = (v.err ? v.sel : 4'b0000) | other;
        @(negedge aclk);
        per_ready = '0; per_err = '0;
        chk($sformatf("v%0d_done_latency", id), write_done | read_done, 1);
        chk($sformatf("v%0d_valid_drop", id), per_valid, 0);
      end else begin
        vcnt = 1;
        while (vcnt < 40) begin
          @(negedge aclk);
          if (!per_valid) break;
          vcnt++;
        end
        per_ready = '0; per_err = '0;
        chk($sformatf("v%0d_timeout_cycles", id), vcnt, 8);
        chk($sformatf("v%0d_timeout_done", id), write_done | read_done, 1);
      end
    end
    @(negedge aclk);
  endtask

  task automatic serve(input logic exp_we, input logic [3:0] exp_sel, input string nm, output int waited);
    waited = 0;
    while (!per_valid && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    chk({nm, "_granted"}, per_valid, 1);
    chk({nm, "_we"}, per_we, exp_we);
    chk({nm, "_sel"}, per_sel, exp_sel);
    per_ready = exp_sel;
    @(negedge aclk);
    per_ready = '0;
  endtask

  initial begin
    int w;
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 4'b0010, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 2, 1'b0, 4'b0100, 2'b00, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 1'b0, 4'b0000, 2'b11, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_3000, 32'hA5A5_0001, 4'hF, -1, 1'b0, 4'b1000, 2'b10, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 1'b1, 4'b1000, 2'b10, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 0, 1'b0, 4'b0010, 2'b00, 32'h1111_2222};
    vecs[6] = '{1'b1, 32'h0000_0008, 32'h0000_BEEF, 4'h3, 3, 1'b1, 4'b0001, 2'b10, 32'h0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h1, 4'hF, 0, 1'b0, 4'b0000, 2'b11, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, -1, 1'b0, 4'b0001, 2'b10, 32'h0};

    repeat (2) @(negedge aclk);
    chk("rst_valid", per_valid, 0);
    chk("rst_done", {write_done, read_done}, 0);
    chk("rst_sel", per_sel, 0);
    chk("rst_rdata", rdata, 0);
    arst_n = 1'b1;
    @(negedge aclk);
    chk("post_rst_idle", {per_valid, write_done, read_done}, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Collision after reset: write first, then read.
    @(negedge aclk);
    req_write = 1'b1; req_waddr = 32'h0; req_wdata = 32'h55AA; req_wstrb = 4'hF;
    req_read  = 1'b1; req_raddr = 32'h2000;
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    sb_q.push_back('{1'b0, 2'b00, 32'h1234_5678});
    @(negedge aclk);
    req_write = 1'b0; req_read = 1'b0;
    serve(1'b1, 4'b0001, "col1_first", w);
    serve(1'b0, 4'b0100, "col1_second", w);
    chk("col1_idle_gap", w, 2);
    repeat (2) @(negedge aclk);

    // Next collision: read first.
    req_write = 1'b1; req_waddr = 32'h1000; req_wdata = 32'h77; req_wstrb = 4'h1;
    req_read  = 1'b1; req_raddr = 32'h3000;
    sb_q.push_back('{1'b0, 2'b00, 32'h3333_4444});
    sb_q.push_back('{1'b1, 2'b00, 32'h0});
    @(negedge aclk);
    req_write = 1'b0; req_read = 1'b0;
    serve(1'b0, 4'b1000, "col2_first", w);
    serve(1'b1, 4'b0010, "col2_second", w);
    repeat (2) @(negedge aclk);

    // Reset while an access is outstanding.
    req_write = 1'b1; req_waddr = 32'h1000; req_wdata = 32'h9; req_wstrb = 4'hF;
    @(negedge aclk);
    req_write = 1'b0;
    @(negedge aclk);
    chk("mid_rst_pre_valid", per_valid, 1);
    #3 arst_n = 1'b0;
    #1;
    chk("mid_rst_valid_async", per_valid, 0);
    chk("mid_rst_sel_async", per_sel, 0);
    @(negedge aclk);
    arst_n = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("mid_rst_no_done", {write_done, read_done}, 0);
    end
    run_vec(vecs[0], 9);

    repeat (3) @(negedge aclk);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
